tl_ul_uart: RTL and testbench

// TileLink-UL slave UART on one tl_switch slave port (s_a_*/s_d_*); drives UART_TX, samples UART_RX.
// 8N1 serial with TX/RX FIFOs, a 4-word register map and a level IRQ into the CPU external_irq input.

---
 rtl/tl_ul_uart_if.sv | 39 +++
 rtl/tl_ul_uart.sv | 257 +++++++++++++++++++++++++
 tb/tb_tl_ul_uart.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_ul_uart_if.sv
// TileLink-UL A/D channel bundle for a single slave port.
// The host side takes the master modport and the UART takes the slave modport.
interface tl_ul_uart_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned SID_WIDTH = 8
);
    logic                 tl_a_valid;
    logic                 tl_a_ready;
    logic [2:0]           tl_a_opcode;
    logic [2:0]           tl_a_param;
    logic [2:0]           tl_a_size;
    logic [SID_WIDTH-1:0] tl_a_source;
    logic [XLEN-1:0]      tl_a_address;
    logic [XLEN/8-1:0]    tl_a_mask;
    logic [XLEN-1:0]      tl_a_data;
    logic                 tl_d_valid;
    logic                 tl_d_ready;
    logic [2:0]           tl_d_opcode;
    logic [1:0]           tl_d_param;
    logic [2:0]           tl_d_size;
    logic [SID_WIDTH-1:0] tl_d_source;
    logic [XLEN-1:0]      tl_d_data;
    logic                 tl_d_corrupt;
    logic                 tl_d_denied;

    modport master (
        output tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address,
               tl_a_mask, tl_a_data, tl_d_ready,
        input  tl_a_ready, tl_d_valid, tl_d_opcode, tl_d_param, tl_d_size, tl_d_source,
               tl_d_data, tl_d_corrupt, tl_d_denied
    );

    modport slave (
        input  tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address,
               tl_a_mask, tl_a_data, tl_d_ready,
        output tl_a_ready, tl_d_valid, tl_d_opcode, tl_d_param, tl_d_size, tl_d_source,
               tl_d_data, tl_d_corrupt, tl_d_denied
    );
endinterface

// File: rtl/tl_ul_uart.sv
// TileLink-UL slave UART: 8N1 TX/RX with FIFOs, DATA/STATUS/CTRL/DIV registers and a level IRQ.
// One outstanding request; the D response is always registered.
module tl_ul_uart #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned SID_WIDTH    = 8,
    parameter int unsigned CLK_FREQ_MHZ = 27,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    tl_ul_uart_if.slave tl,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DivRst = 16'(CLK_FREQ_MHZ * 1_000_000 / BAUD);
    localparam logic [AW:0] PtrOne = (AW+1)'(1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

    logic [7:0]          tx_mem [FIFO_DEPTH];
    logic [7:0]          rx_mem [FIFO_DEPTH];
    logic [AW:0]         tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic                tx_full, tx_empty, rx_full, rx_empty;
    logic                tx_push, tx_pop, tx_drop, rx_push, rx_pop;
    logic [1:0]          ctrl_q;
    logic [15:0]         div_q, div_wr;
    logic                overrun_q, frame_err_q, ovr_set, ferr_set, irq_q;
    logic                d_valid_q, d_corrupt_q, d_denied_q;
    logic [2:0]          d_opcode_q, d_size_q;
    logic [SID_WIDTH-1:0] d_source_q;
    logic [XLEN-1:0]     d_data_q, rdata;
    logic                accept, is_put, is_get, status_rd;
    logic [1:0]          reg_sel;
    uart_st_e            tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [15:0]         tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [15:0]         rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]          tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]          tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [1:0]          rx_sync_q;
    logic                rx_prev_q, rx_in;
    logic                unused_bits;

    assign unused_bits = ^{tl.tl_a_param, tl.tl_a_address[XLEN-1:4], tl.tl_a_address[1:0],
                           tl.tl_a_data[XLEN-1:16], tl.tl_a_mask[XLEN/8-1:2]};

    assign tx_empty = tx_wp_q == tx_rp_q;
    assign rx_empty = rx_wp_q == rx_rp_q;
    assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);

    // Bus decode
    assign tl.tl_a_ready = !d_valid_q;
    assign accept    = tl.tl_a_valid && !d_valid_q;
    assign is_put    = (tl.tl_a_opcode == 3'd0) || (tl.tl_a_opcode == 3'd1);
    assign is_get    = tl.tl_a_opcode == 3'd4;
    assign reg_sel   = tl.tl_a_address[3:2];
    assign tx_push   = accept && is_put && reg_sel == 2'd0 && tl.tl_a_mask[0] && (!tx_full || tx_pop);
    assign tx_drop   = accept && is_put && reg_sel == 2'd0 && tl.tl_a_mask[0] && tx_full && !tx_pop;
    assign rx_pop    = accept && is_get && reg_sel == 2'd0 && !rx_empty;
    assign status_rd = accept && is_get && reg_sel == 2'd1;

    always_comb begin
        div_wr[15:8] = tl.tl_a_mask[1] ? tl.tl_a_data[15:8] : div_q[15:8];
        div_wr[7:0]  = tl.tl_a_mask[0] ? tl.tl_a_data[7:0]  : div_q[7:0];
        if (div_wr < 16'd16) div_wr = 16'd16;
    end

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            2'd0:    rdata[7:0]  = rx_empty ? 8'h00 : rx_mem[rx_rp_q[AW-1:0]];
            2'd1:    rdata[5:0]  = {frame_err_q, tx_st_q != StIdle, overrun_q, !rx_empty,
                                    tx_empty, tx_full};
            2'd2:    rdata[1:0]  = ctrl_q;
            default: rdata[15:0] = div_q;
        endcase
    end

    assign tl.tl_d_valid   = d_valid_q;
    assign tl.tl_d_opcode  = d_opcode_q;
    assign tl.tl_d_param   = 2'd0;
    assign tl.tl_d_size    = d_size_q;
    assign tl.tl_d_source  = d_source_q;
    assign tl.tl_d_data    = d_data_q;
    assign tl.tl_d_corrupt = d_corrupt_q;
    assign tl.tl_d_denied  = d_denied_q;
    assign irq             = irq_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_valid_q   <= 1'b0;
            d_opcode_q  <= 3'd0;
            d_size_q    <= 3'd0;
            d_source_q  <= '0;
            d_data_q    <= '0;
            d_corrupt_q <= 1'b0;
            d_denied_q  <= 1'b0;
        end else if (accept) begin
            // Arithmetic/Logical expect data back, so they are denied in AccessAckData form.
            d_valid_q   <= 1'b1;
            d_opcode_q  <= (is_get || tl.tl_a_opcode inside {3'd2, 3'd3}) ? 3'd1 : 3'd0;
            d_size_q    <= tl.tl_a_size;
            d_source_q  <= tl.tl_a_source;
            d_data_q    <= is_get ? rdata : '0;
            d_corrupt_q <= tl.tl_a_opcode inside {3'd2, 3'd3};
            d_denied_q  <= !(is_put || is_get) || tx_drop;
        end else if (d_valid_q && tl.tl_d_ready) begin
            d_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q      <= 2'd0;
            div_q       <= DivRst;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
        end else begin
            if (accept && is_put && reg_sel == 2'd2 && tl.tl_a_mask[0]) ctrl_q <= tl.tl_a_data[1:0];
            if (accept && is_put && reg_sel == 2'd3) div_q <= div_wr;
            // A new error in the same cycle as the clearing read stays visible.
            overrun_q   <= (overrun_q && !status_rd) || ovr_set;
            frame_err_q <= (frame_err_q && !status_rd) || ferr_set;
            irq_q       <= (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_empty);
            if (tx_push) tx_wp_q <= tx_wp_q + PtrOne;
            if (tx_pop)  tx_rp_q <= tx_rp_q + PtrOne;
            if (rx_push) rx_wp_q <= rx_wp_q + PtrOne;
            if (rx_pop)  rx_rp_q <= rx_rp_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= tl.tl_a_data[7:0];
        if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_st_q    <= StIdle;
            tx_cnt_q   <= 16'd0;
            tx_div_q   <= DivRst;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            rx_st_q    <= StIdle;
            rx_cnt_q   <= 16'd0;
            rx_div_q   <= DivRst;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
        end else begin
            tx_st_q    <= tx_st_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_sync_q  <= {rx_sync_q[0], uart_rx};
            rx_prev_q  <= rx_in;
        end
    end

    // Divisor is latched per bit so a DIV write lands on the next bit boundary.
    always_comb begin
        tx_st_d    = tx_st_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        if (tx_st_q == StIdle) begin
            tx_cnt_d = 16'd0;
            if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_st_d    = StStart;
                tx_shift_d = tx_mem[tx_rp_q[AW-1:0]];
                tx_div_d   = div_q;
            end
        end else if (tx_cnt_q == tx_div_q - 16'd1) begin
            tx_cnt_d = 16'd0;
            tx_div_d = div_q;
            unique case (tx_st_q)
                StStart: begin
                    tx_st_d  = StData;
                    tx_bit_d = 3'd0;
                end
                StData: begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_st_d = StStop;
                end
                default: tx_st_d = StIdle;
            endcase
        end
    end

    always_comb begin
        unique case (tx_st_q)
            StStart: uart_tx = 1'b0;
            StData:  uart_tx = tx_shift_q[0];
            default: uart_tx = 1'b1;
        endcase
    end

    assign rx_in = rx_sync_q[1];

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        unique case (rx_st_q)
            StIdle: begin
                rx_cnt_d = 16'd0;
                if (rx_prev_q && !rx_in) begin
                    rx_st_d  = StStart;
                    rx_div_d = div_q;
                end
            end
            StStart: if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
                rx_cnt_d = 16'd0;
                rx_div_d = div_q;
                rx_bit_d = 3'd0;
                rx_st_d  = rx_in ? StIdle : StData;
            end
            StData: if (rx_cnt_q == rx_div_q - 16'd1) begin
                rx_cnt_d   = 16'd0;
                rx_div_d   = div_q;
                rx_shift_d = {rx_in, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = StStop;
            end
            default: if (rx_cnt_q == rx_div_q - 16'd1) begin
                rx_st_d = StIdle;
                if (!rx_in)                   ferr_set = 1'b1;
                else if (rx_full && !rx_pop)  ovr_set  = 1'b1;
                else                          rx_push  = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_tl_ul_uart.sv
// Directed bench for tl_ul_uart: register access, TX waveform, RX path, FIFO limits, IRQ and reset.
module tb_tl_ul_uart;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;
    logic irq;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0]  tb_source = 8'h00;
    logic [31:0] rd, rd2;
    logic        den, den2, den_any;

    tl_ul_uart_if #(.XLEN(32), .SID_WIDTH(8)) tl ();

    tl_ul_uart dut (
        .clk     (clk),
        .reset   (reset),
        .tl      (tl),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tl_access(input logic [2:0] op, input logic [3:0] addr, input logic [31:0] wdata,
                             input logic [3:0] mask, output logic [31:0] rdata, output logic denied);
        int n;
        @(negedge clk);
        tl.tl_a_valid   = 1'b1;
        tl.tl_a_opcode  = op;
        tl.tl_a_address = {28'd0, addr};
        tl.tl_a_data    = wdata;
        tl.tl_a_mask    = mask;
        tl.tl_a_source  = tb_source;
        tl.tl_a_size    = 3'd2;
        n = 0;
        while (!tl.tl_a_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tl.tl_a_valid = 1'b0;
        n = 0;
        while (!tl.tl_d_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tl.tl_d_valid) check("d_valid timeout", 32'(tl.tl_d_valid), 32'd1);
        rdata  = tl.tl_d_data;
        denied = tl.tl_d_denied;
    endtask

    task automatic get_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic        d;
        tl_access(3'd4, addr, 32'd0, 4'h0, r, d);
        check(tag, r, exp);
    endtask

    task automatic put(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] r;
        logic        d;
        tl_access(3'd0, addr, data, mask, r, d);
    endtask

    // Drives one 8N1 frame at 16 clocks per bit.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (16) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic tx_monitor(input logic [7:0] b);
        int          n;
        logic [15:0] s;
        logic [9:0]  frame;
        frame = {1'b1, b, 1'b0};
        n = 0;
        while (uart_tx && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (uart_tx) check("tx start timeout", 32'(uart_tx), 32'd0);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 16; j++) begin
                s[j] = uart_tx;
                @(negedge clk);
            end
            check($sformatf("tx bit%0d", k), 32'(s), {16'd0, {16{frame[k]}}});
        end
    endtask

    initial begin
        tl.tl_a_valid = 1'b0;
        tl.tl_a_opcode = 3'd0;
        tl.tl_a_param = 3'd0;
        tl.tl_a_size = 3'd0;
        tl.tl_a_source = 8'd0;
        tl.tl_a_address = 32'd0;
        tl.tl_a_mask = 4'h0;
        tl.tl_a_data = 32'd0;
        tl.tl_d_ready = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst uart_tx", 32'(uart_tx), 32'd1);
        check("rst d_valid", 32'(tl.tl_d_valid), 32'd0);
        check("rst a_ready", 32'(tl.tl_a_ready), 32'd1);
        check("rst irq", 32'(irq), 32'd0);
        tb_source = 8'h5a;
        tl_access(3'd4, 4'hC, 32'd0, 4'h0, rd, den);
        check("rst DIV", rd, 32'd234);
        check("d_source echo", 32'(tl.tl_d_source), 32'h5a);
        tb_source = 8'h00;
        get_chk("rst STATUS", 4'h4, 32'h02);

        // DIV lane masking and clamping
        put(4'hC, 32'h0000_1234, 4'b0010);
        get_chk("DIV lane1 only", 4'hC, 32'h0000_12ea);
        put(4'hC, 32'd5, 4'hF);
        get_chk("DIV clamp", 4'hC, 32'd16);
        put(4'h0, 32'h99, 4'h0);
        get_chk("DATA mask0 no push", 4'h4, 32'h02);

        // TX frame of 0x55 at DIV=16
        fork
            tx_monitor(8'h55);
            begin
                tl_access(3'd0, 4'h0, 32'h55, 4'h1, rd2, den2);
                check("tx put denied", 32'(den2), 32'd0);
                get_chk("STATUS tx busy", 4'h4, 32'h12);
            end
        join
        get_chk("STATUS tx done", 4'h4, 32'h02);

        // RX single byte
        send_rx(8'hA5, 1'b1);
        get_chk("STATUS rx nonempty", 4'h4, 32'h06);
        get_chk("RX data A5", 4'h0, 32'hA5);
        get_chk("STATUS rx drained", 4'h4, 32'h02);

        // RX overrun on the ninth byte
        for (int i = 0; i < 9; i++) send_rx(8'(8'h10 + i), 1'b1);
        get_chk("STATUS overrun", 4'h4, 32'h0E);
        get_chk("STATUS overrun clr", 4'h4, 32'h06);
        for (int i = 0; i < 8; i++) get_chk($sformatf("RX fifo %0d", i), 4'h0, 32'(8'h10 + i));
        tl_access(3'd4, 4'h0, 32'd0, 4'h0, rd, den);
        check("RX empty read", {rd[30:0], den}, 32'd0);

        // Frame error discards byte
        send_rx(8'h77, 1'b0);
        get_chk("STATUS frame_err", 4'h4, 32'h22);
        get_chk("STATUS frame_err clr", 4'h4, 32'h02);

        // D held while d_ready low
        @(negedge clk);
        tl.tl_d_ready   = 1'b0;
        tl.tl_a_valid   = 1'b1;
        tl.tl_a_opcode  = 3'd4;
        tl.tl_a_address = 32'hC;
        @(negedge clk);
        tl.tl_a_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold d cyc%0d", i),
                  32'({tl.tl_d_valid, tl.tl_a_ready, tl.tl_d_opcode, tl.tl_d_denied,
                       tl.tl_d_data[15:0]}),
                  32'({1'b1, 1'b0, 3'd1, 1'b0, 16'd16}));
            @(negedge clk);
        end
        tl.tl_d_ready = 1'b1;
        @(negedge clk);
        check("hold released", 32'({tl.tl_d_valid, tl.tl_a_ready}), 32'b01);
        tl_access(3'd2, 4'h0, 32'd0, 4'hF, rd, den);
        check("opcode2 denied", 32'(den), 32'd1);

        // IRQ with one cycle lag
        put(4'h8, 32'h1, 4'h1);
        check("irq idle", 32'(irq), 32'd0);
        send_rx(8'h3C, 1'b1);
        check("irq rx", 32'(irq), 32'd1);
        get_chk("RX data 3C", 4'h0, 32'h3C);
        check("irq lag", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq drained", 32'(irq), 32'd0);
        put(4'h8, 32'h2, 4'h1);
        @(negedge clk);
        check("irq tx_empty", 32'(irq), 32'd1);
        put(4'h8, 32'h0, 4'h1);
        get_chk("CTRL readback", 4'h8, 32'h0);

        // TX FIFO full, then reset mid-frame
        put(4'hC, 32'd1000, 4'hF);
        den_any = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tl_access(3'd0, 4'h0, 32'(i), 4'h1, rd, den);
            den_any |= den;
        end
        check("tx fill no deny", 32'(den_any), 32'd0);
        tl_access(3'd0, 4'h0, 32'hEE, 4'h1, rd, den);
        check("tx full denied", 32'(den), 32'd1);
        get_chk("STATUS tx full", 4'h4, 32'h11);
        @(negedge clk);
        check("mid-frame tx low", 32'(uart_tx), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("async reset tx", 32'(uart_tx), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        get_chk("post-reset DIV", 4'hC, 32'd234);
        get_chk("post-reset STATUS", 4'h4, 32'h02);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
